// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the RAM arbiter and its download write buffer.
package ram_arb_pkg;

  localparam int unsigned ACCESS_CYCLES_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_DL  = 2'd0,
    OWN_VID = 2'd1,
    OWN_CPU = 2'd2
  } owner_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the arbiter and its requesters/RAM.
// slave: arbiter side, master: requester/RAM side.
interface ram_arbiter_if #(
  parameter int unsigned ADDR_W = 25
);
  logic              dl_wr;
  logic [ADDR_W-1:0] dl_a;
  logic [7:0]        dl_d;
  logic              downloading;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_a;
  logic [7:0]        cpu_d;
  logic              cpu_ack;
  logic [7:0]        cpu_q;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_a;
  logic              vid_ack;
  logic [7:0]        vid_q;
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_d;
  logic              ram_we;
  logic              ram_oe;
  logic [7:0]        ram_q;
  logic              cpu_hold;
  logic              dl_ovf;

  modport slave (
    input  dl_wr, dl_a, dl_d, downloading,
    input  cpu_req, cpu_we, cpu_a, cpu_d,
    input  vid_req, vid_a, ram_q,
    output cpu_ack, cpu_q, vid_ack, vid_q,
    output ram_a, ram_d, ram_we, ram_oe, cpu_hold, dl_ovf
  );

  modport master (
    output dl_wr, dl_a, dl_d, downloading,
    output cpu_req, cpu_we, cpu_a, cpu_d,
    output vid_req, vid_a, ram_q,
    input  cpu_ack, cpu_q, vid_ack, vid_q,
    input  ram_a, ram_d, ram_we, ram_oe, cpu_hold, dl_ovf
  );
endinterface

// File: rtl/dl_wbuf.sv
// One-entry download write buffer: captures loader strobes, is drained by
// the arbiter, and flags strobes lost because the entry was still occupied.
module dl_wbuf #(
  parameter int unsigned ADDR_W = 25
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_a,
  input  logic [7:0]        i_d,
  input  logic              i_consume,
  input  logic              i_downloading,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_a,
  output logic [7:0]        o_d,
  output logic              o_ovf
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_a;
  logic [7:0]        r_d;
  logic              r_ovf;
  logic              r_dl_prev;
  logic              w_dl_rise;
  logic              w_drop;

  assign w_dl_rise = i_downloading & ~r_dl_prev;
  assign w_drop    = i_wr & r_valid & ~i_consume;

  // Entry capture/drain and sticky overflow; a drop on the same edge as a
  // session start still sets the flag, since the loss happened in the new session.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_a       <= '0;
      r_d       <= '0;
      r_ovf     <= 1'b0;
      r_dl_prev <= 1'b0;
    end else begin
      r_dl_prev <= i_downloading;
      if (i_wr && (!r_valid || i_consume)) begin
        r_valid <= 1'b1;
        r_a     <= i_a;
        r_d     <= i_d;
      end else if (i_consume) begin
        r_valid <= 1'b0;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_dl_rise) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_a     = r_a;
  assign o_d     = r_d;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: download buffer > video > CPU, fixed-length
// accesses followed by a one-cycle completion slot.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = 25,
  parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  ram_arbiter_if.slave  bus
);

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES);

  state_e            r_state;
  owner_e            r_owner;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_ram_a;
  logic [7:0]        r_ram_d;
  logic              r_we;
  logic              r_oe;
  logic              r_cpu_ack;
  logic              r_vid_ack;
  logic [7:0]        r_cpu_q;
  logic [7:0]        r_vid_q;

  logic              w_buf_valid;
  logic [ADDR_W-1:0] w_buf_a;
  logic [7:0]        w_buf_d;
  logic              w_dl_ovf;
  logic              w_idle;
  logic              w_grant_dl;
  logic              w_grant_vid;
  logic              w_grant_cpu;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_grant_dl  = w_idle & w_buf_valid;
  assign w_grant_vid = w_idle & ~w_buf_valid & bus.vid_req;
  assign w_grant_cpu = w_idle & ~w_buf_valid & ~bus.vid_req & bus.cpu_req & ~bus.downloading;

  dl_wbuf #(
    .ADDR_W (ADDR_W)
  ) u_wbuf (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_wr          (bus.dl_wr),
    .i_a           (bus.dl_a),
    .i_d           (bus.dl_d),
    .i_consume     (w_grant_dl),
    .i_downloading (bus.downloading),
    .o_valid       (w_buf_valid),
    .o_a           (w_buf_a),
    .o_d           (w_buf_d),
    .o_ovf         (w_dl_ovf)
  );

  // Grant, hold the RAM strobes for the access, capture read data and pulse ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_owner   <= OWN_DL;
      r_cnt     <= '0;
      r_ram_a   <= '0;
      r_ram_d   <= '0;
      r_we      <= 1'b0;
      r_oe      <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_vid_ack <= 1'b0;
      r_cpu_q   <= '0;
      r_vid_q   <= '0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_vid_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_grant_dl) begin
            r_state <= ST_ACCESS;
            r_owner <= OWN_DL;
            r_ram_a <= w_buf_a;
            r_ram_d <= w_buf_d;
            r_we    <= 1'b1;
            r_oe    <= 1'b0;
            r_cnt   <= 4'd1;
          end else if (w_grant_vid) begin
            r_state <= ST_ACCESS;
            r_owner <= OWN_VID;
            r_ram_a <= bus.vid_a;
            r_ram_d <= '0;
            r_we    <= 1'b0;
            r_oe    <= 1'b1;
            r_cnt   <= 4'd1;
          end else if (w_grant_cpu) begin
            r_state <= ST_ACCESS;
            r_owner <= OWN_CPU;
            r_ram_a <= bus.cpu_a;
            r_ram_d <= bus.cpu_d;
            r_we    <= bus.cpu_we;
            r_oe    <= ~bus.cpu_we;
            r_cnt   <= 4'd1;
          end
        end
        ST_ACCESS: begin
          if (r_cnt == LAST_CNT) begin
            r_state <= ST_DONE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_oe    <= 1'b0;
            if (r_oe && r_owner == OWN_VID) r_vid_q <= bus.ram_q;
            if (r_oe && r_owner == OWN_CPU) r_cpu_q <= bus.ram_q;
            r_vid_ack <= (r_owner == OWN_VID);
            r_cpu_ack <= (r_owner == OWN_CPU);
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ram_a    = r_ram_a;
  assign bus.ram_d    = r_ram_d;
  assign bus.ram_we   = r_we;
  assign bus.ram_oe   = r_oe;
  assign bus.cpu_ack  = r_cpu_ack;
  assign bus.vid_ack  = r_vid_ack;
  assign bus.cpu_q    = r_cpu_q;
  assign bus.vid_q    = r_vid_q;
  assign bus.dl_ovf   = w_dl_ovf;
  assign bus.cpu_hold = bus.downloading |
                        (bus.cpu_req & ~w_idle & (r_owner == OWN_DL));

endmodule
